// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Avalon-MM pipelined read master. Fetches a contiguous block of 32-bit
//   words from SDRAM and streams them through a show-ahead output FIFO to
//   the scanout / readback consumer. Runs entirely in the clk domain.
//
//   Flow control: a read is only issued when the FIFO can absorb every word
//   already in flight plus the new one, and the number of outstanding reads
//   stays at or below MAX_PENDING. The FIFO therefore cannot overflow.
//
// Parameters
//   ADDR_W       byte-address width of the master port
//   CNT_W        width of the word-count register
//   FIFO_DEPTH   output FIFO entries (power of two, >= 4)
//   MAX_PENDING  cap on outstanding reads (<= FIFO_DEPTH)
//
// Ports
//   clk, rst_n                system clock, asynchronous active-low reset
//   start                     one-cycle pulse, latches base_addr/word_count
//   base_addr, word_count     transfer base (bits [1:0] ignored) and length
//   busy, done                transfer in progress / end-of-transfer pulse
//   master_*                  Avalon-MM pipelined read master
//   out_data, out_valid,
//   out_ready                 FIFO head, not-empty flag, consumer accept
//
// Optional build macro
//   FRAMEBUFFER_READER_UNDERFLOW_CNT_EN adds underflow_count[15:0]: saturating
//   count of busy cycles where the consumer was ready but the FIFO was empty.
//   Cleared on start acceptance and on reset.

module framebuffer_reader #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned CNT_W       = 20,
   parameter int unsigned FIFO_DEPTH  = 64,
   parameter int unsigned MAX_PENDING = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] master_address,
   output logic              master_read,
   input  logic              master_wait_request,
   input  logic [31:0]       master_read_data,
   input  logic              master_read_data_valid,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef FRAMEBUFFER_READER_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]       underflow_count
`endif
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   issue_left;
   logic [CNT_W-1:0]   recv_left;
   logic [PEND_W-1:0]  pending;

   logic [31:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FCNT_W-1:0]  fifo_count;

   logic [31:0]        inflight;
   logic               credit_ok;
   logic               accept;
   logic               rd_ok;
   logic               push;
   logic               pop;
   logic               last_pop;
   logic               unused_addr_lsbs;

   // Alignment bits of base_addr are deliberately discarded.
   assign unused_addr_lsbs = &{1'b0, base_addr[1:0]};

   // Credit is derived from registered state only, so read_data_valid has no
   // combinational path to master_read. Within a stall credit can only grow
   // (returns move words from pending into the FIFO, pops free slots), so
   // master_read and master_address stay stable while wait_request is high.
   always_comb begin
      inflight  = 32'(fifo_count) + 32'(pending);
      credit_ok = (inflight < FIFO_DEPTH) && (32'(pending) < MAX_PENDING);
   end

   assign master_read    = (state == ISSUE) && (issue_left != '0) && credit_ok;
   assign master_address = addr_q;
   assign accept         = master_read && !master_wait_request;

   // Returned beats outside a transfer or with nothing outstanding are dropped.
   assign rd_ok = master_read_data_valid && (state != IDLE) && (pending != '0);
   assign push  = rd_ok;

   assign out_valid = (fifo_count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid && out_ready;

   // The last word has arrived (recv_left==0) and is leaving an otherwise
   // empty FIFO.
   assign last_pop = (state == DRAIN) && (recv_left == '0) && pop &&
                     (fifo_count == FCNT_W'(1)) && !push;

   // Control FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         issue_left <= '0;
         recv_left  <= '0;
         pending    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;

         case ({accept, rd_ok})
            2'b10:   pending <= pending + PEND_W'(1);
            2'b01:   pending <= pending - PEND_W'(1);
            default: pending <= pending;
         endcase

         if (rd_ok) begin
            recv_left <= recv_left - CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     addr_q     <= {base_addr[ADDR_W-1:2], 2'b00};
                     issue_left <= word_count;
                     recv_left  <= word_count;
                     busy       <= 1'b1;
                     state      <= ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               if (accept) begin
                  addr_q     <= addr_q + ADDR_W'(4);
                  issue_left <= issue_left - CNT_W'(1);
                  if (issue_left == CNT_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (last_pop) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage (no reset needed: out_data is masked while empty)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= master_read_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
            2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

`ifdef FRAMEBUFFER_READER_UNDERFLOW_CNT_EN
   // Consumer starvation counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_count <= '0;
      end else if ((state == IDLE) && start) begin
         underflow_count <= '0;
      end else if (busy && out_ready && !out_valid && (underflow_count != '1)) begin
         underflow_count <= underflow_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader
//   Directed bench for framebuffer_reader. A cycle task plays the Avalon
//   slave (fixed read latency, optional wait_request window) and the
//   consumer. Every accepted request pushes the data the slave will return
//   for the expected address onto a scoreboard; every FIFO pop is checked
//   against the scoreboard head.

module tb_framebuffer_reader;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned CNT_W       = 20;
   localparam int unsigned FIFO_DEPTH  = 64;
   localparam int unsigned MAX_PENDING = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] master_address;
   logic              master_read;
   logic              master_wait_request;
   logic [31:0]       master_read_data;
   logic              master_read_data_valid;
   logic [31:0]       out_data;
   logic              out_valid;
   logic              out_ready;
`ifdef FRAMEBUFFER_READER_UNDERFLOW_CNT_EN
   logic [15:0]       underflow_count;
`endif

   framebuffer_reader #(
      .ADDR_W      (ADDR_W),
      .CNT_W       (CNT_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .MAX_PENDING (MAX_PENDING)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .start                  (start),
      .base_addr              (base_addr),
      .word_count             (word_count),
      .busy                   (busy),
      .done                   (done),
      .master_address         (master_address),
      .master_read            (master_read),
      .master_wait_request    (master_wait_request),
      .master_read_data       (master_read_data),
      .master_read_data_valid (master_read_data_valid),
      .out_data               (out_data),
      .out_valid              (out_valid),
      .out_ready              (out_ready)
`ifdef FRAMEBUFFER_READER_UNDERFLOW_CNT_EN
      ,
      .underflow_count        (underflow_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   int          checks    = 0;
   int          errors    = 0;
   int          cyc       = 0;
   int          start_cyc = 0;
   int          lat       = 2;
   int          stall_lo  = 1000000;
   int          stall_hi  = 1000000;
   int          issued    = 0;
   int          returned  = 0;
   int          popped    = 0;
   int          done_seen = 0;
   int          pend_max  = 0;
   logic        rdy       = 1'b1;
   logic        prev_wait = 1'b0;
   logic        held_rd   = 1'b0;
   logic [31:0] held_addr = '0;
   logic [31:0] exp_addr  = '0;
   logic [31:0] exp_q [$];
   rsp_t        rsp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic tick();
      int rel;
      int pend;
      logic [31:0] exp_word;
      // Data returned on the previous edge must already be visible.
      chk("out_valid", 32'(out_valid), 32'((returned - popped) > 0));

      rel = cyc - start_cyc;
      master_wait_request = (rel >= stall_lo) && (rel <= stall_hi);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         master_read_data_valid = 1'b1;
         master_read_data       = rsp_q[0].data;
         void'(rsp_q.pop_front());
         returned++;
      end else begin
         master_read_data_valid = 1'b0;
         master_read_data       = '0;
      end
      out_ready = rdy;
      #1;

      if (master_wait_request) begin
         if (prev_wait) begin
            chk("stall_read", 32'(master_read), 32'(held_rd));
            chk("stall_addr", master_address, held_addr);
         end
         held_rd   = master_read;
         held_addr = master_address;
      end
      prev_wait = master_wait_request;

      if (master_read && !master_wait_request) begin
         chk("addr", master_address, exp_addr);
         exp_q.push_back(data_of(exp_addr));
         rsp_q.push_back('{cyc + lat, data_of(master_address)});
         exp_addr = exp_addr + 32'd4;
         issued++;
      end

      if (out_valid && out_ready) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_word = exp_q.pop_front();
            chk("out_data", out_data, exp_word);
         end
         popped++;
      end

      if (done) done_seen++;

      pend = issued - returned;
      if (pend > pend_max) pend_max = pend;
      chk("pending_cap", 32'(pend <= int'(MAX_PENDING)), 32'd1);
      chk("no_overflow", 32'((issued - popped) <= int'(FIFO_DEPTH)), 32'd1);

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_xfer(input logic [31:0] base, input int cnt, input bit acc);
      start      = 1'b1;
      base_addr  = base;
      word_count = CNT_W'(cnt);
      if (acc) begin
         start_cyc = cyc;
         exp_addr  = base & ~32'h3;
      end
      tick();
      start = 1'b0;
   endtask

   task automatic finish_xfer(input string tag, input int cnt, input int p0, input int d0);
      int n = 0;
      while (done_seen == d0 && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_seen != d0), 32'd1);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      repeat (3) tick();
      chk({tag, "_done_once"}, 32'(done_seen - d0), 32'd1);
      chk({tag, "_words"}, 32'(popped - p0), 32'(cnt));
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int p0;
      int d0;
      int i0;
      int n;

      rst_n                  = 1'b0;
      start                  = 1'b0;
      base_addr              = '0;
      word_count             = '0;
      master_wait_request    = 1'b0;
      master_read_data       = '0;
      master_read_data_valid = 1'b0;
      out_ready              = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_read", 32'(master_read), 32'd0);
      chk("rst_addr", master_address, 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic read: 8 words from 0x100, latency 2, consumer always ready
      p0 = popped; d0 = done_seen;
      start_xfer(32'h100, 8, 1'b1);
      chk("basic_first_read", 32'(master_read), 32'd1);
      chk("basic_first_addr", master_address, 32'h100);
      chk("basic_busy", 32'(busy), 32'd1);
      finish_xfer("basic", 8, p0, d0);

      // Zero-length transfer
      d0 = done_seen;
      start_xfer(32'h200, 0, 1'b0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_read", 32'(master_read), 32'd0);
      chk("zero_busy", 32'(busy), 32'd0);
      tick();
      chk("zero_done_pulse", 32'(done), 32'd0);
      chk("zero_done_once", 32'(done_seen - d0), 32'd1);

      // Unaligned base: low address bits dropped
      p0 = popped; d0 = done_seen;
      start_xfer(32'h103, 3, 1'b1);
      chk("unaligned_first_addr", master_address, 32'h100);
      finish_xfer("unaligned", 3, p0, d0);

      // Slave stall on cycles 3..7 of the transfer
      p0 = popped; d0 = done_seen;
      stall_lo = 3; stall_hi = 7;
      start_xfer(32'h300, 10, 1'b1);
      finish_xfer("stall", 10, p0, d0);
      stall_lo = 1000000; stall_hi = 1000000;

      // Start while busy is ignored
      p0 = popped; d0 = done_seen;
      start_xfer(32'h400, 6, 1'b1);
      tick(); tick();
      start_xfer(32'h800, 9, 1'b0);
      finish_xfer("ignore_start", 6, p0, d0);

      // Backpressure: consumer stalled, issuing must stop at a full FIFO
      p0 = popped; d0 = done_seen; i0 = issued;
      rdy = 1'b0;
      start_xfer(32'h4000, 100, 1'b1);
      repeat (200) tick();
      chk("bp_issued", 32'(issued - i0), 32'(FIFO_DEPTH));
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      rdy = 1'b1;
      finish_xfer("bp", 100, p0, d0);

      // Pending cap with long read latency
      p0 = popped; d0 = done_seen;
      lat = 20; pend_max = 0;
      start_xfer(32'h8000, 12, 1'b1);
      finish_xfer("pend", 12, p0, d0);
      chk("pend_max", 32'(pend_max), 32'(MAX_PENDING));
      lat = 2;

      // Reset in the middle of a 16-word transfer
      p0 = popped;
      start_xfer(32'h1000, 16, 1'b1);
      n = 0;
      while ((popped - p0) < 5 && n < 200) begin
         tick();
         n++;
      end
      chk("mid_words_before_reset", 32'(popped - p0), 32'd5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_read", 32'(master_read), 32'd0);
      chk("mid_rst_addr", master_address, 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", out_data, 32'd0);
      exp_q.delete();
      rsp_q.delete();
      issued = 0; returned = 0; popped = 0;
      master_read_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Stray late beat while idle must be dropped
      master_read_data_valid = 1'b1;
      master_read_data       = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      master_read_data_valid = 1'b0;
      master_read_data       = '0;
      cyc = cyc + 4;
      chk("stray_out_valid", 32'(out_valid), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_out_data", out_data, 32'd0);
      tick();
      p0 = popped; d0 = done_seen;
      start_xfer(32'h2000, 4, 1'b1);
      finish_xfer("after_reset", 4, p0, d0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
